// File: rtl/regfile_pkg.sv
// regfile_pkg: shared register-file constants and the writeback entry type.
package regfile_pkg;
  localparam int DATAWIDTH = 32;
  localparam int REGISTERS = 32;
  localparam int INDEX = $clog2(REGISTERS);
  typedef struct packed {
    logic [INDEX-1:0] addr;
    logic [DATAWIDTH-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: synchronous FIFO of wb_entry_t; entries exposed oldest-first with valid bits.
module wb_fifo
  import regfile_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic            pop,
  input  wb_entry_t       din,
  output wb_entry_t       ent [DEPTH],
  output logic [DEPTH-1:0] ent_valid,
  output logic [CW-1:0]   count
);
  wb_entry_t mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= din;
  // ent[0] is the head; higher indices are younger entries
  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    assign ent[i] = mem[rd_ptr + AW'(i)];
    assign ent_valid[i] = CW'(i) < count;
  end
endmodule

// File: rtl/regfile_writer.sv
// regfile_writer: buffered register-file write port with x0 filter and RAW query.
// Optional forwarding of pending data on q_data under REGFILE_WRITER_BYPASS_EN.
module regfile_writer
  import regfile_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [INDEX-1:0]     in_addr,
  input  logic [DATAWIDTH-1:0] in_data,
  input  logic                 hold,
  output logic                 werf,
  output logic [INDEX-1:0]     wa,
  output logic [DATAWIDTH-1:0] wd,
  input  logic [INDEX-1:0]     q_addr,
  output logic                 q_pending,
  output logic [DATAWIDTH-1:0] q_data,
  output logic [CW-1:0]        count
);
  wb_entry_t ent [DEPTH];
  logic [DEPTH-1:0] ent_valid, hit;
  logic push, pop;
  assign in_ready = rst_n && (count < CW'(DEPTH));
  assign push = in_valid && in_ready && (in_addr != '0);
  assign pop = (count != '0) && !hold;
  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(push),
    .pop(pop),
    .din('{addr: in_addr, data: in_data}),
    .ent(ent),
    .ent_valid(ent_valid),
    .count(count)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      werf <= 1'b0;
      wa <= '0;
      wd <= '0;
    end else begin
      werf <= pop;
      if (pop) begin
        wa <= ent[0].addr;
        wd <= ent[0].data;
      end
    end
  for (genvar i = 0; i < DEPTH; i++) begin : g_hit
    assign hit[i] = ent_valid[i] && (ent[i].addr == q_addr);
  end
  assign q_pending = (q_addr != '0) && ((|hit) || (werf && wa == q_addr));
`ifdef REGFILE_WRITER_BYPASS_EN
  // youngest match wins: later FIFO slots override older ones and the output register
  always_comb begin
    q_data = (werf && wa == q_addr) ? wd : '0;
    for (int k = 0; k < DEPTH; k++) if (hit[k]) q_data = ent[k].data;
    if (!q_pending) q_data = '0;
  end
`else
  assign q_data = '0;
`endif
endmodule

// File: tb/tb_regfile_writer.sv
// tb_regfile_writer: randomized and directed checks against a queue-based model.
module tb_regfile_writer;
  import regfile_pkg::*;
  localparam int DEPTH = 4;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, hold = 1'b0;
  logic in_ready, werf, q_pending;
  logic [INDEX-1:0] in_addr = '0, wa, q_addr = '0;
  logic [DATAWIDTH-1:0] in_data = '0, wd, q_data;
  logic [$clog2(DEPTH):0] count;
  regfile_writer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_data(in_data), .hold(hold), .werf(werf),
    .wa(wa), .wd(wd), .q_addr(q_addr), .q_pending(q_pending),
    .q_data(q_data), .count(count)
  );
  always #5 clk = ~clk;
  int passed = 0, total = 0, n_w = 0;
  wb_entry_t mq[$];
  logic m_werf = 1'b0;
  logic [INDEX-1:0] m_wa = '0, c_a = '0;
  logic [DATAWIDTH-1:0] m_wd = '0, c_d = '0;
  logic c_en = 1'b0;
  logic [DATAWIDTH-1:0] rf [REGISTERS];
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  function automatic logic m_qpend();
    if (q_addr == '0) return 1'b0;
    foreach (mq[i]) if (mq[i].addr == q_addr) return 1'b1;
    return m_werf && m_wa == q_addr;
  endfunction
  function automatic logic [DATAWIDTH-1:0] m_qdata();
`ifdef REGFILE_WRITER_BYPASS_EN
    if (q_addr == '0) return '0;
    for (int i = mq.size() - 1; i >= 0; i--) if (mq[i].addr == q_addr) return mq[i].data;
    if (m_werf && m_wa == q_addr) return m_wd;
`endif
    return '0;
  endfunction
  task automatic compare();
    check("werf", 64'(werf), 64'(m_werf));
    check("wa", 64'(wa), 64'(m_wa));
    check("wd", 64'(wd), 64'(m_wd));
    check("count", 64'(count), 64'(mq.size()));
    check("in_ready", 64'(in_ready), 64'(mq.size() < DEPTH));
    check("q_pending", 64'(q_pending), 64'(m_qpend()));
    check("q_data", 64'(q_data), 64'(m_qdata()));
  endtask
  task automatic step();
    wb_entry_t e;
    bit acc, pp;
    @(posedge clk);
    if (c_en) rf[c_a] = c_d;
    acc = in_valid && (mq.size() < DEPTH);
    pp = (mq.size() > 0) && !hold;
    if (pp) begin
      e = mq.pop_front();
      m_werf = 1'b1;
      m_wa = e.addr;
      m_wd = e.data;
    end else m_werf = 1'b0;
    if (acc && in_addr != '0) mq.push_back('{addr: in_addr, data: in_data});
    #1;
    compare();
    c_en = werf;
    c_a = wa;
    c_d = wd;
    if (werf) n_w++;
  endtask
  task automatic push_one(input int a, input logic [DATAWIDTH-1:0] d);
    in_valid = 1'b1;
    in_addr = INDEX'(a);
    in_data = d;
    step();
    in_valid = 1'b0;
  endtask
  task automatic mid_reset();
    #2 rst_n = 1'b0;
    #1;
    mq.delete();
    m_werf = 1'b0;
    m_wa = '0;
    m_wd = '0;
    c_en = 1'b0;
    check("rst_werf", 64'(werf), 64'(0));
    check("rst_count", 64'(count), 64'(0));
    check("rst_ready", 64'(in_ready), 64'(0));
    check("rst_wa", 64'(wa), 64'(0));
    @(negedge clk) rst_n = 1'b1;
  endtask
  initial begin
    foreach (rf[i]) rf[i] = '0;
    #3;
    check("init_werf", 64'(werf), 64'(0));
    check("init_count", 64'(count), 64'(0));
    check("init_ready", 64'(in_ready), 64'(0));
    check("init_wd", 64'(wd), 64'(0));
    @(negedge clk) rst_n = 1'b1;
    // single write: accepted edge 1, visible after edge 2
    push_one(5, 32'hDEADBEEF);
    step();
    check("sw_werf", 64'(werf), 64'(1));
    check("sw_wa", 64'(wa), 64'(5));
    check("sw_wd", 64'(wd), 64'hDEADBEEF);
    step();
    check("sw_werf_off", 64'(werf), 64'(0));
    check("sw_count", 64'(count), 64'(0));
    // x0 filter
    q_addr = '0;
    in_valid = 1'b1;
    in_addr = '0;
    in_data = 32'h1234;
    check("x0_ready", 64'(in_ready), 64'(1));
    step();
    in_valid = 1'b0;
    check("x0_count", 64'(count), 64'(0));
    check("x0_qpend", 64'(q_pending), 64'(0));
    step();
    check("x0_werf", 64'(werf), 64'(0));
    // fill under hold, then drain in order
    hold = 1'b1;
    for (int r = 1; r <= 4; r++) push_one(r, 32'h100 + r);
    check("full_count", 64'(count), 64'(4));
    check("full_ready", 64'(in_ready), 64'(0));
    push_one(9, 32'h99);
    step();
    check("hold_ready", 64'(in_ready), 64'(0));
    hold = 1'b0;
    for (int r = 1; r <= 4; r++) begin
      step();
      check("drain_werf", 64'(werf), 64'(1));
      check("drain_wa", 64'(wa), 64'(r));
      if (r == 1) check("drain_ready", 64'(in_ready), 64'(1));
    end
    step();
    check("drain_done", 64'(werf), 64'(0));
    // same-register ordering
    hold = 1'b1;
    q_addr = 5'd7;
    push_one(7, 32'hA);
    push_one(7, 32'hB);
    check("r7_pend", 64'(q_pending), 64'(1));
`ifdef REGFILE_WRITER_BYPASS_EN
    check("r7_fwd", 64'(q_data), 64'hB);
`endif
    hold = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("r7_rf", 64'(rf[7]), 64'hB);
    check("r7_clear", 64'(q_pending), 64'(0));
    // sustained streaming
    n_w = 0;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      in_addr = INDEX'(i + 1);
      in_data = $urandom;
      q_addr = INDEX'($urandom_range(0, 31));
      step();
      check("stream_count", 64'(count <= 1), 64'(1));
      check("stream_ready", 64'(in_ready), 64'(1));
    end
    in_valid = 1'b0;
    step();
    step();
    check("stream_writes", 64'(n_w), 64'(20));
    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      in_valid = 1'($urandom_range(0, 3) != 0);
      in_addr = ($urandom_range(0, 7) == 0) ? '0 : INDEX'($urandom_range(1, 6));
      in_data = $urandom;
      hold = 1'($urandom_range(0, 9) < 3);
      q_addr = INDEX'($urandom_range(0, 7));
      step();
    end
    // reset with entries queued and a write in flight
    in_valid = 1'b0;
    hold = 1'b1;
    for (int r = 1; r <= 4; r++) push_one(r, 32'h200 + r);
    hold = 1'b0;
    step();
    check("pre_rst_werf", 64'(werf), 64'(1));
    check("pre_rst_count", 64'(count), 64'(3));
    mid_reset();
    n_w = 0;
    for (int i = 0; i < 6; i++) step();
    check("no_stale", 64'(n_w), 64'(0));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
